// File: rtl/half_duplex_link_ctrl_if.sv
// half_duplex_link_ctrl_if: requester handshakes and shared-datapath signals of the half-duplex link
interface half_duplex_link_ctrl_if;
    logic       req_a;
    logic       req_b;
    logic [7:0] din_a;
    logic [7:0] din_b;
    logic       link_done;
    logic [7:0] link_dout;
    logic [1:0] tx_mode;
    logic       start;
    logic       stop;
    logic [7:0] tx_din;
    logic       ack_a;
    logic       ack_b;
    logic       err_a;
    logic       err_b;
    logic       rx_valid_a;
    logic       rx_valid_b;
    logic [7:0] rx_data;
    logic       busy;
    modport master (
        input  req_a, req_b, din_a, din_b, link_done, link_dout,
        output tx_mode, start, stop, tx_din, ack_a, ack_b, err_a, err_b,
               rx_valid_a, rx_valid_b, rx_data, busy
    );
    modport slave (
        output req_a, req_b, din_a, din_b, link_done, link_dout,
        input  tx_mode, start, stop, tx_din, ack_a, ack_b, err_a, err_b,
               rx_valid_a, rx_valid_b, rx_data, busy
    );
endinterface

// File: rtl/half_duplex_link_ctrl.sv
// half_duplex_link_ctrl: round-robin arbiter and turnaround sequencer for a shared half-duplex transceiver
module half_duplex_link_ctrl #(
    parameter int TIMEOUT = 200,
    parameter int GAP     = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    half_duplex_link_ctrl_if.master lnk
);
    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_GAP} state_t;
    state_t      state_q;
    logic [15:0] cnt_q;
    logic        last_grant_q;
    logic        src_q;
    logic [1:0]  tx_mode_q;
    logic [7:0]  tx_din_q;
    logic [7:0]  rx_data_q;
    logic        start_q, stop_q, ack_a_q, ack_b_q, err_a_q, err_b_q, rxv_a_q, rxv_b_q, busy_q;
    logic        win_b_d;
    // A lone requester wins; on a tie the side not served last goes next
    always_comb win_b_d = lnk.req_b && (!lnk.req_a || !last_grant_q);
    // Transfer sequencer; every output is registered alongside the state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            src_q        <= 1'b0;
            tx_mode_q    <= 2'b00;
            tx_din_q     <= '0;
            rx_data_q    <= '0;
            busy_q       <= 1'b0;
            {start_q, stop_q, ack_a_q, ack_b_q, err_a_q, err_b_q, rxv_a_q, rxv_b_q} <= '0;
        end else begin
            {start_q, stop_q, ack_a_q, ack_b_q, err_a_q, err_b_q, rxv_a_q, rxv_b_q} <= '0;
            case (state_q)
                S_IDLE: if (lnk.req_a || lnk.req_b) begin
                    state_q   <= S_START;
                    src_q     <= win_b_d;
                    tx_din_q  <= win_b_d ? lnk.din_b : lnk.din_a;
                    tx_mode_q <= win_b_d ? 2'b10 : 2'b01;
                    start_q   <= 1'b1;
                    busy_q    <= 1'b1;
                end
                S_START: begin
                    state_q <= S_WAIT;
                    cnt_q   <= '0;
                end
                S_WAIT: if (lnk.link_done || cnt_q == 16'(TIMEOUT - 1)) begin
                    state_q      <= S_GAP;
                    cnt_q        <= '0;
                    tx_mode_q    <= 2'b00;
                    last_grant_q <= src_q;
                    if (lnk.link_done) begin
                        rx_data_q <= lnk.link_dout;
                        rxv_a_q   <= src_q;
                        rxv_b_q   <= !src_q;
                        ack_a_q   <= !src_q;
                        ack_b_q   <= src_q;
                    end else begin
                        stop_q  <= 1'b1;
                        err_a_q <= !src_q;
                        err_b_q <= src_q;
                    end
                end else begin
                    cnt_q <= cnt_q + 16'd1;
                end
                S_GAP: if (cnt_q == 16'(GAP - 1)) begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end else begin
                    cnt_q <= cnt_q + 16'd1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
    assign lnk.tx_mode    = tx_mode_q;
    assign lnk.start      = start_q;
    assign lnk.stop       = stop_q;
    assign lnk.tx_din     = tx_din_q;
    assign lnk.ack_a      = ack_a_q;
    assign lnk.ack_b      = ack_b_q;
    assign lnk.err_a      = err_a_q;
    assign lnk.err_b      = err_b_q;
    assign lnk.rx_valid_a = rxv_a_q;
    assign lnk.rx_valid_b = rxv_b_q;
    assign lnk.rx_data    = rx_data_q;
    assign lnk.busy       = busy_q;
endmodule

// File: tb/tb_half_duplex_link_ctrl.sv
// tb_half_duplex_link_ctrl: scoreboard bench for the half-duplex link controller
module tb_half_duplex_link_ctrl;
    localparam int TIMEOUT = 200;
    localparam int GAP     = 4;
    typedef struct packed {
        logic       b;
        logic [7:0] d;
        logic       err;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    exp_t sb[$];
    exp_t e_m;
    half_duplex_link_ctrl_if lnk ();
    half_duplex_link_ctrl #(.TIMEOUT(TIMEOUT), .GAP(GAP)) dut (.clk(clk), .rst(rst), .lnk(lnk));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // scoreboard consumer: every ack/err pulse is matched against the oldest expected transfer
    always @(negedge clk) if (!rst) begin
        if (lnk.ack_a | lnk.ack_b | lnk.err_a | lnk.err_b) begin
            if (sb.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
            else begin
                e_m = sb.pop_front();
                chk("acks", 32'({lnk.ack_b, lnk.ack_a}), e_m.err ? 32'd0 : (e_m.b ? 32'd2 : 32'd1));
                chk("errs", 32'({lnk.err_b, lnk.err_a}), e_m.err ? (e_m.b ? 32'd2 : 32'd1) : 32'd0);
                chk("stop", 32'(lnk.stop), 32'(e_m.err));
                chk("rx_valid", 32'({lnk.rx_valid_b, lnk.rx_valid_a}), e_m.err ? 32'd0 : (e_m.b ? 32'd1 : 32'd2));
                if (!e_m.err) chk("rx_data", 32'(lnk.rx_data), 32'(e_m.d));
            end
        end else if (lnk.rx_valid_a | lnk.rx_valid_b | lnk.stop)
            chk("stray_pulse", 32'({lnk.stop, lnk.rx_valid_b, lnk.rx_valid_a}), 32'd0);
        if (lnk.tx_mode == 2'b11) chk("tx_mode11", 32'(lnk.tx_mode), 32'd0);
    end

    task automatic request(input logic b, input logic [7:0] d, input logic err, output int t0);
        @(posedge clk);
        #1;
        if (b) begin
            lnk.req_b = 1'b1;
            lnk.din_b = d;
        end else begin
            lnk.req_a = 1'b1;
            lnk.din_a = d;
        end
        sb.push_back(exp_t'{b, d, err});
        t0 = cyc;
    endtask

    task automatic serve(input logic b, input logic [7:0] d, input int t0, input int lat,
                         input int wait_n, input logic done, input logic drop);
        int s = -1;
        int e = -1;
        for (int i = 0; i < 50 && s < 0; i++) begin
            @(negedge clk);
            if (lnk.start) s = cyc;
        end
        if (s < 0) begin
            chk("start_timeout", 32'd0, 32'd1);
            return;
        end
        chk("start_lat", 32'(s - t0), 32'(lat));
        chk("tx_mode", 32'(lnk.tx_mode), b ? 32'd2 : 32'd1);
        chk("tx_din", 32'(lnk.tx_din), 32'(d));
        @(posedge clk);
        #1;
        if (drop) begin
            if (b) lnk.req_b = 1'b0;
            else lnk.req_a = 1'b0;
        end
        if (done) begin
            repeat (wait_n) @(posedge clk);
            #1;
            lnk.link_done = 1'b1;
            lnk.link_dout = d;
            @(posedge clk);
            #1;
            lnk.link_done = 1'b0;
        end
        for (int i = 0; i < TIMEOUT + 50 && e < 0; i++) begin
            @(negedge clk);
            if (b ? (lnk.ack_b | lnk.err_b) : (lnk.ack_a | lnk.err_a)) e = cyc;
        end
        if (e < 0) chk("done_timeout", 32'd0, 32'd1);
        else chk("done_lat", 32'(e - s), done ? 32'(wait_n + 2) : 32'(TIMEOUT + 1));
        chk("tx_din_hold", 32'(lnk.tx_din), 32'(d));
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (lnk.busy && n < 50);
        chk("idle", 32'(lnk.busy), 32'd0);
    endtask

    task automatic pulse_link(input logic [7:0] d);
        @(posedge clk);
        #1;
        lnk.link_done = 1'b1;
        lnk.link_dout = d;
        @(posedge clk);
        #1;
        lnk.link_done = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0;
        lnk.req_a = 1'b0;
        lnk.req_b = 1'b0;
        lnk.din_a = '0;
        lnk.din_b = '0;
        lnk.link_done = 1'b0;
        lnk.link_dout = '0;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_tx_mode", 32'(lnk.tx_mode), 32'd0);
        chk("rst_busy", 32'(lnk.busy), 32'd0);
        chk("rst_tx_din", 32'(lnk.tx_din), 32'd0);
        chk("rst_rx_data", 32'(lnk.rx_data), 32'd0);
        chk("rst_pulses", 32'({lnk.start, lnk.stop, lnk.ack_a, lnk.ack_b, lnk.err_a, lnk.err_b,
                               lnk.rx_valid_a, lnk.rx_valid_b}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        // A -> B completion after 10 WAIT cycles, then a 4-cycle turnaround
        request(1'b0, 8'hA5, 1'b0, t0);
        serve(1'b0, 8'hA5, t0, 1, 10, 1'b1, 1'b0);
        lnk.req_a = 1'b0;
        chk("gap_mode", 32'(lnk.tx_mode), 32'd0);
        repeat (GAP - 1) begin
            @(negedge clk);
            chk("gap_busy", 32'(lnk.busy), 32'd1);
            chk("gap_mode", 32'(lnk.tx_mode), 32'd0);
        end
        @(negedge clk);
        chk("gap_end_idle", 32'(lnk.busy), 32'd0);
        // link_done while idle is ignored
        pulse_link(8'hFF);
        @(negedge clk);
        chk("idle_rx_data", 32'(lnk.rx_data), 32'hA5);
        chk("idle_busy", 32'(lnk.busy), 32'd0);
        // B timeout, then link_done during the gap is ignored
        request(1'b1, 8'h3C, 1'b1, t0);
        serve(1'b1, 8'h3C, t0, 1, 0, 1'b0, 1'b0);
        lnk.req_b = 1'b0;
        pulse_link(8'h77);
        @(negedge clk);
        chk("gap_rx_data", 32'(lnk.rx_data), 32'hA5);
        wait_idle();
        // completion on the last WAIT cycle beats the timeout
        request(1'b0, 8'h5E, 1'b0, t0);
        serve(1'b0, 8'h5E, t0, 1, TIMEOUT - 1, 1'b1, 1'b0);
        lnk.req_a = 1'b0;
        wait_idle();
        // request dropped right after the grant still completes
        request(1'b1, 8'hC3, 1'b0, t0);
        serve(1'b1, 8'hC3, t0, 1, 3, 1'b1, 1'b1);
        wait_idle();
        // both sides held from reset alternate A, B, A, B
        @(posedge clk);
        #1;
        rst = 1'b1;
        lnk.req_a = 1'b1;
        lnk.req_b = 1'b1;
        lnk.din_a = 8'h11;
        lnk.din_b = 8'h22;
        @(posedge clk);
        #1;
        rst = 1'b0;
        t0 = cyc;
        for (int k = 0; k < 4; k++) sb.push_back(exp_t'{k[0], k[0] ? 8'h22 : 8'h11, 1'b0});
        for (int k = 0; k < 4; k++) begin
            serve(k[0], k[0] ? 8'h22 : 8'h11, t0, k == 0 ? 1 : GAP + 1, 2, 1'b1, 1'b0);
            t0 = cyc;
        end
        lnk.req_a = 1'b0;
        lnk.req_b = 1'b0;
        wait_idle();
        // reset mid-WAIT abandons the transfer; the held request is served again
        @(posedge clk);
        #1;
        lnk.req_a = 1'b1;
        lnk.din_a = 8'h5A;
        for (int i = 0; i < 10 && !lnk.start; i++) @(negedge clk);
        chk("pre_rst_start", 32'(lnk.start), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        t0 = cyc;
        @(negedge clk);
        chk("post_rst_mode", 32'(lnk.tx_mode), 32'd0);
        chk("post_rst_busy", 32'(lnk.busy), 32'd0);
        chk("post_rst_pulses", 32'({lnk.ack_a, lnk.err_a, lnk.stop}), 32'd0);
        sb.push_back(exp_t'{1'b0, 8'h5A, 1'b0});
        serve(1'b0, 8'h5A, t0, 1, 4, 1'b1, 1'b0);
        lnk.req_a = 1'b0;
        wait_idle();
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
